// File: rtl/i2c_pkg.sv
// Shared constants for the I2C controller: state encoding, mode values, bit phase timing.
package i2c_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_START     = 4'd1;
  localparam logic [3:0] ST_ADDR      = 4'd2;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd3;
  localparam logic [3:0] ST_WRITE     = 4'd4;
  localparam logic [3:0] ST_WRITE_ACK = 4'd5;
  localparam logic [3:0] ST_READ      = 4'd6;
  localparam logic [3:0] ST_READ_NACK = 4'd7;
  localparam logic [3:0] ST_STOP      = 4'd8;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int         PHASES     = 4;
  localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);
  localparam logic [3:0] LAST_BIT   = 4'd7;

  // SCL level for a given state/phase; data and ack bits share one waveform.
  function automatic logic scl_level(input logic [3:0] st, input logic [1:0] ph);
    case (st)
      ST_IDLE:  return 1'b1;
      ST_START: return (ph != 2'd3);
      ST_STOP:  return (ph != 2'd0);
      default:  return (ph == 2'd1) || (ph == 2'd2);
    endcase
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running divider: tick is high for one clk out of every DIV (always high when DIV=1).
module i2c_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == TOP) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == TOP);

endmodule

// File: rtl/i2c_controller.sv
// Single-master I2C controller: START, address+R/W, one data byte, STOP per request.
// Define I2C_CTRL_DEBUG_EN to expose {nack, mode, 2'b00, bit_cnt} on debug; otherwise debug is 0.
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode,
  input  logic [6:0] periph_addr,
  input  logic [7:0] transmit_byte,
  output logic [7:0] byte_reg,
  output logic       ready,
  output logic [3:0] state,
  output logic       scl,
  inout  wire        sda,
  output logic [7:0] debug
);

  logic       tick;
  logic [1:0] phase;
  logic [1:0] phase_n;
  logic [3:0] state_n;
  logic [3:0] bit_cnt;
  logic [3:0] bit_cnt_n;
  logic       last_phase;
  logic [7:0] addr_byte;
  logic [7:0] data_byte;
  logic [7:0] rx_shift;
  logic       mode_latched;
  logic       sample;
  logic       sda_low;
  logic       sda_low_n;
  logic       tx_bit;
  logic       sda_in;

  i2c_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign sda     = sda_low ? 1'b0 : 1'bz;
  assign sda_in  = sda;
  assign ready   = (state == ST_IDLE);
  assign last_phase = (phase == LAST_PHASE);

  always_comb begin
    state_n   = state;
    phase_n   = phase + 2'd1;
    bit_cnt_n = bit_cnt;
    case (state)
      ST_IDLE: begin
        phase_n   = 2'd0;
        bit_cnt_n = 4'd0;
        if (enable) begin
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (last_phase) begin
          state_n = ST_ADDR;
        end
      end
      ST_ADDR, ST_WRITE, ST_READ: begin
        if (last_phase) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n = 4'd0;
            state_n   = (state == ST_ADDR)  ? ST_ADDR_ACK :
                        (state == ST_WRITE) ? ST_WRITE_ACK : ST_READ_NACK;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      ST_ADDR_ACK: begin
        if (last_phase) begin
          if (sample) begin
            state_n = ST_STOP;
          end else begin
            state_n = (mode_latched == MODE_WRITE) ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_WRITE_ACK, ST_READ_NACK: begin
        if (last_phase) begin
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (last_phase) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n   = ST_IDLE;
        phase_n   = 2'd0;
        bit_cnt_n = 4'd0;
      end
    endcase
  end

  // Bus levels are computed from the next state so SCL/SDA come straight out of flops.
  always_comb begin
    tx_bit = 1'b1;
    if (state_n == ST_ADDR) begin
      tx_bit = addr_byte[3'd7 - bit_cnt_n[2:0]];
    end else if (state_n == ST_WRITE) begin
      tx_bit = data_byte[3'd7 - bit_cnt_n[2:0]];
    end
    case (state_n)
      ST_START:          sda_low_n = (phase_n != 2'd0);
      ST_ADDR, ST_WRITE: sda_low_n = ~tx_bit;
      ST_STOP:           sda_low_n = (phase_n < 2'd2);
      default:           sda_low_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      phase        <= 2'd0;
      bit_cnt      <= 4'd0;
      scl          <= 1'b1;
      sda_low      <= 1'b0;
      addr_byte    <= 8'h00;
      data_byte    <= 8'h00;
      mode_latched <= 1'b0;
      rx_shift     <= 8'h00;
      sample       <= 1'b0;
      byte_reg     <= 8'h00;
    end else if (tick) begin
      state   <= state_n;
      phase   <= phase_n;
      bit_cnt <= bit_cnt_n;
      scl     <= scl_level(state_n, phase_n);
      sda_low <= sda_low_n;
      if (state == ST_IDLE && enable) begin
        addr_byte    <= {periph_addr, (mode == MODE_READ)};
        data_byte    <= transmit_byte;
        mode_latched <= mode;
      end
      // Leaving phase 1 is the start of phase 2, where the bus bit is sampled.
      if (phase == 2'd1) begin
        sample <= sda_in;
        if (state == ST_READ) begin
          rx_shift <= {rx_shift[6:0], sda_in};
        end
      end
      if (state == ST_READ && last_phase && bit_cnt == LAST_BIT) begin
        byte_reg <= rx_shift;
      end
    end
  end

`ifdef I2C_CTRL_DEBUG_EN
  logic nack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nack <= 1'b0;
    end else if (tick) begin
      if (state == ST_IDLE && enable) begin
        nack <= 1'b0;
      end else if ((state == ST_ADDR_ACK || state == ST_WRITE_ACK) && last_phase && sample) begin
        nack <= 1'b1;
      end
    end
  end

  assign debug = {nack, mode_latched, 2'b00, bit_cnt};
`else
  assign debug = 8'h00;
`endif

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench: DIV=1 controller with a reactive slave model, plus a DIV=4 instance with no slave.
module tb_i2c_controller;
  import i2c_pkg::*;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       enable4;
  logic       mode;
  logic [6:0] periph_addr;
  logic [7:0] transmit_byte;
  logic [7:0] byte_reg, byte_reg4;
  logic       ready, ready4;
  logic [3:0] state, state4;
  logic       scl, scl4;
  logic [7:0] debug, debug4;
  wire        sda;
  wire        sda4;

  logic       slave_low;
  logic       slave_ack;
  logic [7:0] slave_rd_data;

  int vectors = 0;
  int miscompares = 0;

  pullup (sda);
  pullup (sda4);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_controller #(.DIV(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .periph_addr   (periph_addr),
    .transmit_byte (transmit_byte),
    .byte_reg      (byte_reg),
    .ready         (ready),
    .state         (state),
    .scl           (scl),
    .sda           (sda),
    .debug         (debug)
  );

  i2c_controller #(.DIV(4)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable4),
    .mode          (mode),
    .periph_addr   (periph_addr),
    .transmit_byte (transmit_byte),
    .byte_reg      (byte_reg4),
    .ready         (ready4),
    .state         (state4),
    .scl           (scl4),
    .sda           (sda4),
    .debug         (debug4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave/monitor: decodes START/STOP, records address and data frames, ACKs and returns read data.
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       scl_now, sda_now;
  logic       active = 1'b0;
  int         bit_pos = 0;
  int         byte_num = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         addr_frames = 0;
  int         data_frames = 0;
  logic [7:0] mon_shift = 8'h00;
  logic [7:0] mon_addr = 8'h00;
  logic [7:0] mon_data = 8'h00;
  logic       mon_addr_ack = 1'b0;
  logic       mon_data_ack = 1'b0;

  initial slave_low = 1'b0;

  always @(scl, sda) begin
    scl_now = (scl === 1'b1);
    sda_now = (sda !== 1'b0);
    if (scl_now && prev_scl && prev_sda && !sda_now) begin
      active    = 1'b1;
      bit_pos   = 0;
      byte_num  = 0;
      slave_low = 1'b0;
      start_cnt++;
    end else if (scl_now && prev_scl && !prev_sda && sda_now && active) begin
      active = 1'b0;
      stop_cnt++;
    end else if (scl_now && !prev_scl && active) begin
      if (bit_pos < 8) begin
        mon_shift = {mon_shift[6:0], sda_now};
      end else if (bit_pos == 8) begin
        if (byte_num == 0) begin
          mon_addr     = mon_shift;
          mon_addr_ack = !sda_now;
          addr_frames++;
        end else if (byte_num == 1) begin
          mon_data     = mon_shift;
          mon_data_ack = !sda_now;
          data_frames++;
        end
      end
      bit_pos++;
    end else if (!scl_now && prev_scl && active) begin
      if (bit_pos == 8) begin
        slave_low = (byte_num == 0 || !mon_addr[0]) ? slave_ack : 1'b0;
      end else if (bit_pos == 9) begin
        byte_num++;
        bit_pos   = 0;
        slave_low = (byte_num == 1 && mon_addr[0] && mon_addr_ack) ? !slave_rd_data[7] : 1'b0;
      end else if (byte_num == 1 && mon_addr[0] && bit_pos >= 1 && bit_pos <= 7) begin
        slave_low = !slave_rd_data[7 - bit_pos];
      end
    end
    prev_scl = scl_now;
    prev_sda = sda_now;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One transaction on the DIV=1 instance; enable and inputs are disturbed mid-flight on purpose.
  task automatic apply_stimulus(input logic m, input logic [6:0] a, input logic [7:0] d,
                                input int probe_k, output int ticks, output logic [3:0] probe_state);
    @(negedge clk);
    mode = m;
    periph_addr = a;
    transmit_byte = d;
    enable = 1'b1;
    @(posedge clk);
    #1;
    check_output("start_state", state, ST_START);
    check_output("start_ready", ready, 1'b0);
    enable = 1'b0;
    ticks = 0;
    probe_state = 4'hF;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (k == probe_k) probe_state = state;
      if (k == 20) begin
        enable = 1'b1;
        mode = ~m;
        periph_addr = ~a;
        transmit_byte = ~d;
      end
      if (k == 25) begin
        enable = 1'b0;
        mode = m;
        periph_addr = a;
        transmit_byte = d;
      end
      ticks = k;
      if (ready) break;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         ticks;
    int         af, df, sc, pc;
    int         first_rise, second_rise, rises, cnt;
    logic       prev;
    logic [3:0] probe;

    reset = 1'b0;
    enable = 1'b0;
    enable4 = 1'b0;
    mode = 1'b1;
    periph_addr = 7'h00;
    transmit_byte = 8'h00;
    slave_ack = 1'b1;
    slave_rd_data = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_state", state, ST_IDLE);
    check_output("rst_ready", ready, 1'b1);
    check_output("rst_scl", scl, 1'b1);
    check_output("rst_sda", sda, 1'b1);
    check_output("rst_byte_reg", byte_reg, 8'h00);
    check_output("rst_debug", debug, 8'h00);
    check_output("rst_state4", state4, ST_IDLE);
    check_output("rst_ready4", ready4, 1'b1);
    check_output("rst_scl4", scl4, 1'b1);
    check_output("rst_byte_reg4", byte_reg4, 8'h00);
    check_output("rst_debug4", debug4, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);

    // Write 0x07 to address 0x05; enable wiggles mid-transaction and must be ignored.
    $display("[TB] write addr 0x05 data 0x07");
    af = addr_frames; df = data_frames; sc = start_cnt; pc = stop_cnt;
    slave_ack = 1'b1;
    apply_stimulus(1'b1, 7'h05, 8'h07, 40, ticks, probe);
    check_output("wr_ticks", ticks, 80);
    check_output("wr_probe_state", probe, ST_WRITE);
    check_output("wr_addr_byte", mon_addr, 8'h0A);
    check_output("wr_addr_ack", mon_addr_ack, 1'b1);
    check_output("wr_data_byte", mon_data, 8'h07);
    check_output("wr_data_ack", mon_data_ack, 1'b1);
    check_output("wr_frames", (addr_frames - af) * 16 + (data_frames - df), 17);
    check_output("wr_start_stop", (start_cnt - sc) * 16 + (stop_cnt - pc), 17);
    check_output("wr_byte_reg", byte_reg, 8'h00);
    check_output("wr_state_idle", state, ST_IDLE);
    @(posedge clk);
    #1;
    check_output("wr_no_restart", ready, 1'b1);

    // Read from 0x50; slave returns 0xA5, controller answers with NACK.
    $display("[TB] read addr 0x50");
    slave_rd_data = 8'hA5;
    af = addr_frames; df = data_frames; sc = start_cnt; pc = stop_cnt;
    apply_stimulus(1'b0, 7'h50, 8'h00, 40, ticks, probe);
    check_output("rd_ticks", ticks, 80);
    check_output("rd_probe_state", probe, ST_READ);
    check_output("rd_addr_byte", mon_addr, 8'hA1);
    check_output("rd_addr_ack", mon_addr_ack, 1'b1);
    check_output("rd_bus_data", mon_data, 8'hA5);
    check_output("rd_master_nack", mon_data_ack, 1'b0);
    check_output("rd_frames", (addr_frames - af) * 16 + (data_frames - df), 17);
    check_output("rd_stop", stop_cnt - pc, 1);
    check_output("rd_byte_reg", byte_reg, 8'hA5);
    check_output("rd_ready", ready, 1'b1);

    // Asynchronous reset in the middle of the address byte.
    $display("[TB] reset during address phase");
    @(negedge clk);
    mode = 1'b1;
    periph_addr = 7'h05;
    transmit_byte = 8'h07;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_output("mid_state", state, ST_ADDR);
    check_output("mid_sda_driven", sda, 1'b0);
    reset = 1'b0;
    #1;
    check_output("mid_rst_state", state, ST_IDLE);
    check_output("mid_rst_ready", ready, 1'b1);
    check_output("mid_rst_scl", scl, 1'b1);
    check_output("mid_rst_sda", sda, 1'b1);
    check_output("mid_rst_byte_reg", byte_reg, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // No slave answers: address NACK goes straight to STOP, WRITE never happens.
    $display("[TB] address NACK on write to 0x12");
    slave_ack = 1'b0;
    af = addr_frames; df = data_frames; pc = stop_cnt;
    apply_stimulus(1'b1, 7'h12, 8'h3C, 40, ticks, probe);
    check_output("nack_ticks", ticks, 44);
    check_output("nack_probe_state", probe, ST_STOP);
    check_output("nack_addr_byte", mon_addr, 8'h24);
    check_output("nack_addr_ack", mon_addr_ack, 1'b0);
    check_output("nack_frames", (addr_frames - af) * 16 + (data_frames - df), 16);
    check_output("nack_stop", stop_cnt - pc, 1);
`ifdef I2C_CTRL_DEBUG_EN
    check_output("nack_debug", debug, 8'hC0);
`else
    check_output("nack_debug", debug, 8'h00);
`endif

    // DIV=4 instance with enable held: 16-clk SCL period and one idle tick between transactions.
    $display("[TB] DIV=4 back-to-back");
    @(negedge clk);
    mode = 1'b1;
    periph_addr = 7'h33;
    transmit_byte = 8'h5A;
    enable4 = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      cnt = i;
      if (!ready4) break;
    end
    check_output("div4_started", ready4, 1'b0);
    rises = 0;
    first_rise = 0;
    second_rise = 0;
    prev = scl4;
    for (int i = 1; i <= 200 && rises < 2; i++) begin
      @(posedge clk);
      #1;
      if (!prev && scl4) begin
        if (rises == 0) first_rise = i;
        else second_rise = i;
        rises++;
      end
      prev = scl4;
    end
    check_output("div4_scl_period", second_rise - first_rise, 16);
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (ready4) break;
    end
    check_output("div4_back_idle", ready4, 1'b1);
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      cnt = i;
      if (!ready4) break;
    end
    check_output("div4_idle_clks", cnt, 4);
    cnt = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      cnt = i;
      if (ready4) break;
    end
    check_output("div4_busy_clks", cnt, 176);
    enable4 = 1'b0;
    repeat (8) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_controller.md
Name: i2c_controller

Overview:
- Single-master I2C controller performing one single-byte transaction per request: START, 7-bit address + R/W, one data byte written or read, STOP.
- Sits between a local command source (enable/mode/address/data) and the board I2C bus.
- SCL is push-pull with no clock-stretching support. SDA is open-drain.

Parameters:
- DIV, default 1: system clocks per SCL quarter-phase ("tick"). SCL period = 4*DIV clk cycles. Must be ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  start request, sampled on a tick while in IDLE.
- mode  input  1  1 = WRITE, 0 = READ (bus R/W bit = ~mode).
- periph_addr  input  7  target address, latched at START.
- transmit_byte  input  8  write data, latched at START.
- byte_reg  output  8  last byte read from the bus.
- ready  output  1  high only in IDLE.
- state  output  4  current FSM state encoding.
- scl  output  1  I2C clock, idles high.
- sda  inout  1  I2C data; drive 0 or release to 'z'; never drive 1.
- debug  output  8  status (see Optional Feature).

Behaviour:
- Reset (reset=0, immediate, no STOP generated): state=IDLE, scl=1, sda released, ready=1, byte_reg=0, debug=0, internal counters 0.
- Tick divider: free-running counter asserts tick once every DIV clks. All FSM/bus changes occur only on ticks.
- State encoding:
  - IDLE=0, START=1, ADDR=2, ADDR_ACK=3, WRITE=4, WRITE_ACK=5, READ=6, READ_NACK=7, STOP=8. Others unused; return to IDLE.
- IDLE: on tick with enable=1, latch {periph_addr, ~mode} as address byte, latch transmit_byte and mode, go START.
- Each state/bit lasts 4 ticks (phases 0-3):
  - START: phase0 scl=1, sda released; phase1 sda=0; phase2 hold; phase3 scl=0.
  - Data bits (ADDR, WRITE, ACK states): phase0 scl=0 and sda set; phases 1-2 scl=1, SDA sampled at start of phase2; phase3 scl=0.
  - STOP: phase0 scl=0, sda=0; phase1 scl=1; phase2 sda released; phase3 hold.
- ADDR: 8 bits MSB first, then ADDR_ACK with sda released.
  - Sampled 0: go WRITE if mode=1, else READ.
  - Sampled 1 (NACK): set nack flag, go STOP.
- WRITE: 8 bits of latched byte MSB first, then WRITE_ACK with sda released. NACK sets nack flag. Always go STOP afterwards.
- READ: sda released, 8 bits shifted in MSB first. At end of the 8th bit, byte_reg loads the assembled byte.
- READ_NACK: controller releases sda (NACK, single byte), then STOP.
- STOP then IDLE for at least one tick with ready=1.
  - If enable is still high, a new transaction starts on the next tick.
  - byte_reg is unchanged by write transactions.
- Transaction length: START + 9 + 9 + STOP = 80 ticks.
- enable and input changes are ignored outside IDLE.
- nack flag is cleared at START.

Optional Feature:
- I2C_CTRL_DEBUG_EN defined: debug = {nack, mode_latched, 2'b00, bit_cnt[3:0]}.
- Undefined: debug tied to 8'h00 and the extra logic is removed. Functional bus behaviour is identical either way.

Decomposition:
- Package i2c_pkg: state encoding constants, READ=0/WRITE=1 mode constants, phase count 4.
- One natural sub-module: i2c_tick_gen (DIV divider producing tick).

Test Plan:
- Reset: assert reset=0 mid-transaction -> scl=1, sda=z, state=0, ready=1, byte_reg=0 immediately.
- Write addr 5 data 7, mode=1, enable=1, DIV=1, slave model ACKs -> bus shows START, 0x0A, ACK, 0x07, ACK, STOP. ready low for the transaction, high again after 80 ticks.
- Read addr 0x50, slave returns 0xA5 -> address byte 0xA1, controller NACK, STOP, byte_reg=0xA5, ready=1.
- Address NACK (no slave, sda pulled high) on write to 0x12 -> ADDR_ACK goes to STOP, WRITE skipped, debug[7]=1 with I2C_CTRL_DEBUG_EN.
- enable held high continuously with DIV=4 -> back-to-back transactions with ≥1 IDLE tick, each SCL period = 16 clk cycles.
- enable toggled low mid-write -> transaction completes unaffected.
